// File: rtl/pipeline_stall_controller_if.sv
// Hazard/stall handshake bundle between the pipeline datapath and the
// stall controller. master = datapath side, slave = controller side.
interface pipeline_stall_controller_if;
  logic       id_ex_memRead;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       control_select;
  logic       ex_mem_write;
  logic       mem_wb_write;
  logic       mem_timeout_err;

  modport master (
    output id_ex_memRead, id_ex_rd, if_id_rs1, if_id_rs2,
           branch_taken, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, control_select,
           ex_mem_write, mem_wb_write, mem_timeout_err
  );

  modport slave (
    input  id_ex_memRead, id_ex_rd, if_id_rs1, if_id_rs2,
           branch_taken, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, control_select,
           ex_mem_write, mem_wb_write, mem_timeout_err
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges memory-wait, taken-branch and load-use hazards (in that priority)
// into per-register enables, and watches MEM waits for a timeout.
// Optional build macro HAZARD_PERF_EN adds stall/bubble/flush counters.
module pipeline_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_stall_controller_if.slave   bus
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0]           perf_stall_cycles
  , output logic [CNT_W-1:0]           perf_bubbles
  , output logic [CNT_W-1:0]           perf_flushes
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] CNT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] CNT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic              mem_stall;
  logic              load_use;
  logic              flush_act;
  logic              bubble_act;
  logic              timeout_now;

  // Hazard detection and priority resolution
  always_comb begin
    mem_stall  = bus.dmem_req & ~bus.dmem_ready;
    load_use   = bus.id_ex_memRead & (bus.id_ex_rd != 5'd0) &
                 ((bus.id_ex_rd == bus.if_id_rs1) | (bus.id_ex_rd == bus.if_id_rs2));
    flush_act  = ~mem_stall & bus.branch_taken;
    bubble_act = ~mem_stall & ~bus.branch_taken & load_use;
    // wait_cnt holds completed wait cycles, so the current cycle is the
    // MEM_TIMEOUT-th one when wait_cnt has reached MEM_TIMEOUT-1.
    timeout_now = mem_stall & (wait_cnt >= CNT_LAST);
  end

  // Stage enables, one action per cycle; reset forces a flushed, stopped pipe
  always_comb begin
    bus.pc_write        = 1'b1;
    bus.if_id_write     = 1'b1;
    bus.if_id_flush     = 1'b0;
    bus.control_select  = 1'b1;
    bus.ex_mem_write    = 1'b1;
    bus.mem_wb_write    = 1'b1;
    bus.mem_timeout_err = rst_n & (err_q | timeout_now);
    if (!rst_n) begin
      bus.pc_write       = 1'b0;
      bus.if_id_write    = 1'b0;
      bus.if_id_flush    = 1'b1;
      bus.control_select = 1'b0;
      bus.ex_mem_write   = 1'b0;
      bus.mem_wb_write   = 1'b0;
    end else if (mem_stall) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.ex_mem_write = 1'b0;
      bus.mem_wb_write = 1'b0;
    end else if (flush_act) begin
      bus.if_id_flush    = 1'b1;
      bus.control_select = 1'b0;
    end else if (bubble_act) begin
      bus.pc_write       = 1'b0;
      bus.if_id_write    = 1'b0;
      bus.control_select = 1'b0;
    end
  end

  // RUN/MEM_WAIT state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= mem_stall ? MEM_WAIT : RUN;
  end

  // Saturating wait counter, cleared when the wait ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (mem_stall) begin
      if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
    end else if (state == MEM_WAIT) begin
      wait_cnt <= '0;
    end
  end

  // Sticky timeout flag; the pipeline keeps waiting regardless
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_q <= 1'b0;
    else if (timeout_now) err_q <= 1'b1;
  end

`ifdef HAZARD_PERF_EN
  // Wrapping performance counters for each hazard action
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
      perf_flushes      <= '0;
    end else begin
      if (mem_stall)  perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (bubble_act) perf_bubbles      <= perf_bubbles + 1'b1;
      if (flush_act)  perf_flushes      <= perf_flushes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Table-driven self-checking bench for pipeline_stall_controller with a
// scoreboard queue of expected stage controls.
module tb_pipeline_stall_controller;

  // {pc_write, if_id_write, if_id_flush, control_select, ex_mem_write, mem_wb_write}
  localparam logic [5:0] C_NONE   = 6'b110111;
  localparam logic [5:0] C_FREEZE = 6'b000100;
  localparam logic [5:0] C_FLUSH  = 6'b111011;
  localparam logic [5:0] C_BUBBLE = 6'b000011;
  localparam logic [5:0] C_RESET  = 6'b001000;

  typedef struct {
    string      name;
    logic       mem_read;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       br;
    logic       req;
    logic       rdy;
    logic [5:0] code;
    logic       err;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] code;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int exp_stalls = 0;
  int exp_bubbles = 0;
  int exp_flushes = 0;

  pipeline_stall_controller_if bus ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_flushes;
`endif

  pipeline_stall_controller #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles (perf_stall_cycles)
    , .perf_bubbles      (perf_bubbles)
    , .perf_flushes      (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic mem_read, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                              input logic req, input logic rdy, input logic [5:0] code,
                              input logic err);
    vec_t v;
    v.name = name; v.mem_read = mem_read; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.br = br; v.req = req; v.rdy = rdy; v.code = code; v.err = err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_ex_memRead = v.mem_read;
    bus.id_ex_rd      = v.rd;
    bus.if_id_rs1     = v.rs1;
    bus.if_id_rs2     = v.rs2;
    bus.branch_taken  = v.br;
    bus.dmem_req      = v.req;
    bus.dmem_ready    = v.rdy;
  endtask

  task automatic compare_front();
    exp_t       e;
    logic [5:0] got;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    got = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.control_select,
           bus.ex_mem_write, bus.mem_wb_write};
    if (got !== e.code || bus.mem_timeout_err !== e.err) begin
      errors++;
      $display("FAIL %s: got ctrl=%b err=%b, required ctrl=%b err=%b",
               e.name, got, bus.mem_timeout_err, e.code, e.err);
    end
  endtask

  // One cycle: drive after the rising edge, sample at the falling edge
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    sb.push_back('{v.name, v.code, v.err});
    @(negedge clk);
    compare_front();
    if (v.code == C_FREEZE) exp_stalls++;
    if (v.code == C_BUBBLE) exp_bubbles++;
    if (v.code == C_FLUSH)  exp_flushes++;
  endtask

  task automatic check_perf(input string name);
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_stall_cycles !== 32'(exp_stalls) || perf_bubbles !== 32'(exp_bubbles) ||
        perf_flushes !== 32'(exp_flushes)) begin
      errors++;
      $display("FAIL %s: got stall=%0d bubble=%0d flush=%0d, required %0d %0d %0d", name,
               perf_stall_cycles, perf_bubbles, perf_flushes, exp_stalls, exp_bubbles, exp_flushes);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    vec_t idle;
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, C_NONE, 0);

    tbl[0]  = mk("none",              0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE,   0);
    tbl[1]  = mk("load_use_rs1",      1, 5'd5, 5'd5, 5'd0, 0, 0, 0, C_BUBBLE, 0);
    tbl[2]  = mk("single_bubble",     0, 5'd0, 5'd1, 5'd2, 0, 0, 0, C_NONE,   0);
    tbl[3]  = mk("load_use_rs2",      1, 5'd7, 5'd3, 5'd7, 0, 0, 0, C_BUBBLE, 0);
    tbl[4]  = mk("x0_filter",         1, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_NONE,   0);
    tbl[5]  = mk("no_memread",        0, 5'd9, 5'd9, 5'd9, 0, 0, 0, C_NONE,   0);
    tbl[6]  = mk("rd_mismatch",       1, 5'd4, 5'd6, 5'd8, 0, 0, 0, C_NONE,   0);
    tbl[7]  = mk("branch",            0, 5'd0, 5'd0, 5'd0, 1, 0, 0, C_FLUSH,  0);
    tbl[8]  = mk("branch_over_lu",    1, 5'd5, 5'd5, 5'd0, 1, 0, 0, C_FLUSH,  0);
    tbl[9]  = mk("mem_stall",         0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_FREEZE, 0);
    tbl[10] = mk("stall_over_branch", 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, C_FREEZE, 0);
    tbl[11] = mk("stall_over_lu",     1, 5'd3, 5'd3, 5'd3, 1, 1, 0, C_FREEZE, 0);
    tbl[12] = mk("held_branch_ready", 0, 5'd0, 5'd0, 5'd0, 1, 1, 1, C_FLUSH,  0);
    tbl[13] = mk("ready_no_req",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_NONE,   0);
    tbl[14] = mk("ready_no_req_lu",   1, 5'd2, 5'd2, 5'd0, 0, 0, 1, C_BUBBLE, 0);

    // Reset state
    drive(idle);
    bus.dmem_req = 1'b1;
    @(negedge clk);
    sb.push_back('{"reset_outputs", C_RESET, 1'b0});
    compare_front();
    bus.dmem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 15; i++) step(tbl[i]);
    step(idle);
    check_perf("perf_after_table");

    // MEM wait: three stalled cycles, resume on the fourth
    for (int unsigned i = 0; i < 3; i++) step(mk("mem_wait", 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0));
    step(mk("mem_resume", 0, 0, 0, 0, 0, 1, 1, C_NONE, 0));
    step(idle);
    check_perf("perf_after_wait");

    // Timeout: err visible from the 4th wait cycle, still frozen, sticky
    for (int unsigned i = 1; i <= 6; i++)
      step(mk("timeout_wait", 0, 0, 0, 0, 0, 1, 0, C_FREEZE, (i >= 4) ? 1'b1 : 1'b0));
    step(mk("timeout_resume", 0, 0, 0, 0, 0, 1, 1, C_NONE, 1));
    step(mk("timeout_sticky", 0, 0, 0, 0, 0, 0, 0, C_NONE, 1));
    step(mk("timeout_rewait", 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 1));

    // Reset in the middle of a wait
    step(mk("prereset_wait", 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 1));
    #1;
    rst_n = 1'b0;
    #1;
    sb.push_back('{"reset_mid_wait", C_RESET, 1'b0});
    compare_front();
    drive(idle);
    #1;
    rst_n = 1'b1;
    exp_stalls = 0; exp_bubbles = 0; exp_flushes = 0;
    step(idle);
    check_perf("perf_after_reset");
    // Counter must have been cleared: three more waits stay below the limit
    for (int unsigned i = 0; i < 3; i++) step(mk("post_reset_wait", 0, 0, 0, 0, 0, 1, 0, C_FREEZE, 0));
    step(mk("post_reset_resume", 0, 0, 0, 0, 0, 1, 1, C_NONE, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
